adder_feed_pipe: RTL and testbench



---
 rtl/adder_pkg.sv | 5 +
 rtl/adder_carry_gen.sv | 9 +
 rtl/adder_prefix.sv | 29 ++
 rtl/adder_feed_pipe.sv | 108 ++++++++++
 tb/tb_adder_feed_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared widths for the prefix adder and the pipeline that feeds it.
package adder_pkg;
  localparam int ADD_WIDTH     = 8;
  localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/adder_carry_gen.sv
// Carry-out of an addition reconstructed from the operand and sum MSBs.
module adder_carry_gen (
  input  logic a_msb_i,
  input  logic b_msb_i,
  input  logic sum_msb_i,
  output logic carry_o
);
  assign carry_o = (a_msb_i & b_msb_i) | ((a_msb_i | b_msb_i) & ~sum_msb_i);
endmodule

// File: rtl/adder_prefix.sv
// Combinational Kogge-Stone prefix adder with zero carry-in, sum mod 2^WIDTH.
module adder_prefix
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  // NOTE: every variable written here gets a full default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p0 = a_in ^ b_in;
    g  = a_in & b_in;
    p  = p0;
    // Descending i reads g/p[i-d] before this level overwrites them.
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = WIDTH - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    sum = p0 ^ {g[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/adder_feed_pipe.sv
// Two-stage valid/ready pipeline feeding an external combinational adder,
// with optional running accumulate and carry/operation status.
module adder_feed_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             carry_sticky,
  output logic [CNT_W-1:0] op_count
);
  logic             s1_v_q, s1_acc_q, s2_v_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, acc_q, sum_q;
  logic             carry_q, sticky_q;
  logic [CNT_W-1:0] count_q;

  logic             s2_free, adv, in_xfer, out_xfer, carry_new;
  logic [WIDTH-1:0] acc_d;
  logic             sticky_d;
  logic [CNT_W-1:0] count_d;

  assign s2_free  = ~s2_v_q | out_ready;
  assign adv      = s1_v_q & s2_free;
  assign in_ready = ~s1_v_q | adv;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_v_q & out_ready;

  // Operand b is chosen at the advance, so chained accumulate ops see the freshest acc_q.
  assign add_a = s1_a_q;
  assign add_b = s1_acc_q ? acc_q : s1_b_q;

  adder_carry_gen u_carry (
    .a_msb_i   (add_a[WIDTH-1]),
    .b_msb_i   (add_b[WIDTH-1]),
    .sum_msb_i (add_sum[WIDTH-1]),
    .carry_o   (carry_new)
  );

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (adv) begin
      acc_d    = add_sum;
      sticky_d = acc_clr ? carry_new : (sticky_q | carry_new);
    end else if (acc_clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end
    if (out_xfer) count_d = count_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_v_q   <= 1'b0;
      s1_acc_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s2_v_q   <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (in_xfer) begin
        s1_v_q   <= 1'b1;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_acc_q <= in_acc;
      end else if (adv) begin
        s1_v_q <= 1'b0;
      end
      if (adv) begin
        s2_v_q  <= 1'b1;
        sum_q   <= add_sum;
        carry_q <= carry_new;
      end else if (out_ready) begin
        s2_v_q <= 1'b0;
      end
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign out_valid    = s2_v_q;
  assign out_sum      = sum_q;
  assign out_carry    = carry_q;
  assign carry_sticky = sticky_q;
  assign op_count     = count_q;
endmodule

// File: tb/tb_adder_feed_pipe.sv
// Directed bench for adder_feed_pipe with the real prefix adder attached;
// a queue-based scoreboard checks every result accepted downstream.
module tb_adder_feed_pipe;
  localparam int W  = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_acc, acc_clr;
  logic [W-1:0]  in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic          out_valid, out_ready, out_carry, carry_sticky;
  logic [CW-1:0] op_count;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_acc   = 0;
  int   waits;

  always #5 clk = ~clk;

  adder_feed_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_acc       (in_acc),
    .acc_clr      (acc_clr),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry    (out_carry),
    .carry_sticky (carry_sticky),
    .op_count     (op_count)
  );

  adder_prefix #(.WIDTH(W)) u_adder (
    .a_in (add_a),
    .b_in (add_b),
    .sum  (add_sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops one expectation per output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", {23'd0, out_carry, out_sum}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_sum", {24'd0, out_sum}, {24'd0, e.sum});
        check("sb_carry", {31'd0, out_carry}, {31'd0, e.carry});
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc,
                      input logic [W-1:0] es, input logic ec, output int w);
    w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_acc = acc;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) begin
        check("send_timeout", 32'(w), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    q.push_back('{sum: es, carry: ec});
    n_acc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!out_valid && q.size() == 0) break;
      n++;
      if (n > 60) begin
        check("drain_timeout", 32'(q.size()), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_acc = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {24'd0, out_sum}, 32'd0);
    check("rst_sticky", {31'd0, carry_sticky}, 32'd0);
    check("rst_op_count", {28'd0, op_count}, 32'd0);
    #20 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single op and two-cycle latency.
    send(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, waits);
    @(negedge clk);
    check("lat_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_n2", {31'd0, out_valid}, 32'd1);
    check("lat_sum", {24'd0, out_sum}, 32'h41);
    wait_idle();
    check("count_after_1", {28'd0, op_count}, 32'd1);

    // Wrap-around carry, sticky set, then cleared.
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, waits);
    wait_idle();
    check("sticky_set", {31'd0, carry_sticky}, 32'd1);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("sticky_clr", {31'd0, carry_sticky}, 32'd0);

    // Back-to-back accumulate chain from a cleared accumulator.
    send(8'h10, 8'hAA, 1'b1, 8'h10, 1'b0, waits);
    check("chain0_nowait", 32'(waits), 32'd0);
    send(8'h20, 8'hAA, 1'b1, 8'h30, 1'b0, waits);
    check("chain1_nowait", 32'(waits), 32'd0);
    send(8'hF0, 8'hAA, 1'b1, 8'h20, 1'b1, waits);
    check("chain2_nowait", 32'(waits), 32'd0);
    wait_idle();
    check("chain_sticky", {31'd0, carry_sticky}, 32'd1);

    // Backpressure: five stalled cycles, two ops absorbed, head result held.
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, waits);
        send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, waits);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, waits);
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, waits);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum_stable", {24'd0, out_sum}, 32'h03);
            check("bp_accepted", 32'(n_acc), 32'd2);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("count_after_bp", {28'd0, op_count}, 32'd9);

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, waits);
    send(8'h44, 8'h55, 1'b0, 8'h99, 1'b0, waits);
    #2;
    check("pre_rst_full", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_op_count", {28'd0, op_count}, 32'd0);
    check("arst_sticky", {31'd0, carry_sticky}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h07, 8'h99, 1'b1, 8'h07, 1'b0, waits);
    wait_idle();
    check("post_rst_count", {28'd0, op_count}, 32'd1);

    // Sixteen more results wrap the 4-bit counter back to 1.
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), 8'(i), 1'b0, 8'(2 * i), 1'b0, waits);
    end
    wait_idle();
    check("count_wrap", {28'd0, op_count}, 32'd1);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
